// File: rtl/seq_mul_alu_ctrl_if.sv
// Operand, product and alu port bundle for the shift-add multiplier controller.
// Handshake rule for both in_* and out_*: a transfer happens on a rising clk
// edge where valid && ready are both 1; the sender holds its payload stable
// while valid is high and ready is low.
interface seq_mul_alu_ctrl_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_a;
  logic [DATA_WIDTH-1:0] in_b;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_hi;
  logic [DATA_WIDTH-1:0] out_lo;
  logic                  out_zero;
  logic [DATA_WIDTH-1:0] alu_A;
  logic [DATA_WIDTH-1:0] alu_B;
  logic [2:0]            alu_ALUop;
  logic [DATA_WIDTH-1:0] alu_Result;
  logic                  alu_CarryOut;

  // Multiplier block side.
  modport slave (
    input  in_valid, in_a, in_b, out_ready, alu_Result, alu_CarryOut,
    output in_ready, out_valid, out_hi, out_lo, out_zero, alu_A, alu_B, alu_ALUop
  );

  // Environment side: operand producer, product consumer and the alu.
  modport master (
    output in_valid, in_a, in_b, out_ready, alu_Result, alu_CarryOut,
    input  in_ready, out_valid, out_hi, out_lo, out_zero, alu_A, alu_B, alu_ALUop
  );
endinterface

// File: rtl/seq_mul_alu_ctrl.sv
// Multi-cycle unsigned shift-add multiplier controller. Uses an external
// combinational alu (ADD only) for the partial-product accumulation: each
// CALC cycle adds mcand into hi when lo[0] is set, then shifts {carry,hi,lo}
// right by one. After DATA_WIDTH cycles {hi,lo} holds the full product.
module seq_mul_alu_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_W      = 6
) (
  input  logic                clk,
  input  logic                rst,
  seq_mul_alu_ctrl_if.slave   bus,
  output logic [1:0]          o_dbg_state
);

  localparam logic [2:0]       ALU_ADD  = 3'b010;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic [DATA_WIDTH-1:0]   r_mcand;
  logic [DATA_WIDTH-1:0]   r_hi;
  logic [DATA_WIDTH-1:0]   r_lo;
  logic [CNT_W-1:0]        r_cnt;
  logic                    r_zero;
  logic                    w_accept;
  logic                    w_last;
  logic [2*DATA_WIDTH-1:0] w_next_prod;

  assign w_accept    = (r_state == S_IDLE) && bus.in_valid;
  assign w_last      = (r_cnt == CNT_LAST);
  // Carry becomes the new hi MSB after the shift, so no product bit is lost.
  assign w_next_prod = {bus.alu_CarryOut, bus.alu_Result, r_lo[DATA_WIDTH-1:1]};

  // State register; reset aborts any multiply in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state decode plus handshake and alu drive outputs.
  always_comb begin
    w_next        = r_state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.alu_A     = '0;
    bus.alu_B     = '0;
    bus.alu_ALUop = ALU_ADD;
    case (r_state)
      S_IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) w_next = S_CALC;
      end
      S_CALC: begin
        bus.alu_A = r_hi;
        bus.alu_B = r_lo[0] ? r_mcand : '0;
        if (w_last) w_next = S_DONE;
      end
      S_DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Operand capture, shift-add accumulation and the registered zero flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mcand <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_cnt   <= '0;
      r_zero  <= 1'b1;
    end else if (w_accept) begin
      r_mcand <= bus.in_a;
      r_hi    <= '0;
      r_lo    <= bus.in_b;
      r_cnt   <= '0;
      r_zero  <= ~|bus.in_b;
    end else if (r_state == S_CALC) begin
      r_hi    <= w_next_prod[2*DATA_WIDTH-1:DATA_WIDTH];
      r_lo    <= w_next_prod[DATA_WIDTH-1:0];
      r_zero  <= ~|w_next_prod;
      r_cnt   <= w_last ? '0 : r_cnt + 1'b1;
    end
  end

  assign bus.out_hi   = r_hi;
  assign bus.out_lo   = r_lo;
  assign bus.out_zero = r_zero;
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_seq_mul_alu_ctrl.sv
// Bench for seq_mul_alu_ctrl: behavioural alu, product model (a*b queue),
// per-cycle compare process and directed scenarios with literal results.
module tb_seq_mul_alu_ctrl;

  localparam int W = 32;

  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;
  int         total;
  int         bad;
  int         cyc;
  int         acc_cyc;
  logic       prev_valid;
  logic       carry_seen;
  logic       b_nz_seen;
  logic [2*W-1:0] exp_q[$];

  seq_mul_alu_ctrl_if #(.DATA_WIDTH(W)) bus ();

  seq_mul_alu_ctrl #(.DATA_WIDTH(W), .CNT_W(6)) u_dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus.slave),
    .o_dbg_state (dbg_state)
  );

  // Clock and cycle counter.
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Combinational alu: ADD with carry out.
  always_comb begin
    if (bus.alu_ALUop == 3'b010)
      {bus.alu_CarryOut, bus.alu_Result} = {1'b0, bus.alu_A} + {1'b0, bus.alu_B};
    else
      {bus.alu_CarryOut, bus.alu_Result} = '0;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Compare process: checks the DUT every cycle against the product queue.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      prev_valid = 1'b0;
    end else begin
      chk("alu_op", 64'(bus.alu_ALUop), 64'h2);
      chk("in_ready", 64'(bus.in_ready), 64'(exp_q.size() == 0));
      if (bus.in_ready || bus.out_valid) begin
        chk("alu_A_idle", 64'(bus.alu_A), 64'h0);
        chk("alu_B_idle", 64'(bus.alu_B), 64'h0);
      end else begin
        if (bus.alu_CarryOut) carry_seen = 1'b1;
        if (bus.alu_B != '0) b_nz_seen = 1'b1;
      end
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL spurious_out_valid actual=1 expected=0 (t=%0t)", $time);
        end else begin
          chk("product", {bus.out_hi, bus.out_lo}, exp_q[0]);
          chk("zero", 64'(bus.out_zero), 64'(exp_q[0] == '0));
          if (!prev_valid) chk("latency", 64'(cyc - acc_cyc), 64'(W + 1));
          if (bus.out_ready) void'(exp_q.pop_front());
        end
      end
      prev_valid = bus.out_valid;
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(64'(bus.in_a) * 64'(bus.in_b));
        acc_cyc = cyc;
      end
    end
  end

  // Driver: present an operand pair and hold it until accepted.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
    int k;
    k = 0;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_valid = 1'b1;
    @(negedge clk);
    while (!bus.in_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (!bus.in_ready) begin
      total++;
      bad++;
      $display("FAIL accept_timeout actual=0 expected=1");
    end
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  // Wait (bounded) for out_valid; returns at the negedge where it is seen.
  task automatic wait_valid(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.out_valid && n < 200);
    if (!bus.out_valid) begin
      total++;
      bad++;
      $display("FAIL valid_timeout actual=0 expected=1");
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"}, 64'(bus.in_ready), 64'h1);
    chk({tag, "_out_valid"}, 64'(bus.out_valid), 64'h0);
    chk({tag, "_prod"}, {bus.out_hi, bus.out_lo}, 64'h0);
    chk({tag, "_zero"}, 64'(bus.out_zero), 64'h1);
    chk({tag, "_alu_A"}, 64'(bus.alu_A), 64'h0);
    chk({tag, "_alu_B"}, 64'(bus.alu_B), 64'h0);
    chk({tag, "_alu_op"}, 64'(bus.alu_ALUop), 64'h2);
    chk({tag, "_state"}, 64'(dbg_state), 64'h0);
  endtask

  // Watchdog.
  initial begin
    #2000000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  // Directed scenarios and random sweep.
  initial begin
    int n;
    logic [W-1:0] ra, rb;
    total = 0; bad = 0; cyc = 0; acc_cyc = 0;
    prev_valid = 1'b0; carry_seen = 1'b0; b_nz_seen = 1'b0;
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk_reset_vals("reset");
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    // T1: 3*5, latency 33 cycles.
    send(32'd3, 32'd5);
    wait_valid(n);
    chk("t1_latency", 64'(n), 64'd33);
    chk("t1_hi", 64'(bus.out_hi), 64'h0);
    chk("t1_lo", 64'(bus.out_lo), 64'd15);
    chk("t1_zero", 64'(bus.out_zero), 64'h0);
    @(posedge clk);
    #1 chk("t1_valid_drop", 64'(bus.out_valid), 64'h0);
    chk("t1_ready_back", 64'(bus.in_ready), 64'h1);

    // T2: max*max exercises the carry path.
    carry_seen = 1'b0;
    send(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_valid(n);
    chk("t2_hi", 64'(bus.out_hi), 64'hFFFF_FFFE);
    chk("t2_lo", 64'(bus.out_lo), 64'h0000_0001);
    chk("t2_carry_seen", 64'(carry_seen), 64'h1);
    @(posedge clk);
    #1;

    // T3: zero multiplier, alu_B stays 0 in CALC.
    b_nz_seen = 1'b0;
    send(32'h1234_5678, 32'h0);
    wait_valid(n);
    chk("t3_prod", {bus.out_hi, bus.out_lo}, 64'h0);
    chk("t3_zero", 64'(bus.out_zero), 64'h1);
    chk("t3_b_nonzero", 64'(b_nz_seen), 64'h0);
    @(posedge clk);
    #1;

    // T4: consumer stalls 10 cycles.
    bus.out_ready = 1'b0;
    send(32'd100000, 32'd300000);
    wait_valid(n);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t4_hold_valid", 64'(bus.out_valid), 64'h1);
      chk("t4_hold_ready", 64'(bus.in_ready), 64'h0);
      chk("t4_hold_prod", {bus.out_hi, bus.out_lo}, 64'h0000_0006_FC23_AC00);
    end
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    @(posedge clk);
    #1 chk("t4_valid_drop", 64'(bus.out_valid), 64'h0);
    chk("t4_ready_back", 64'(bus.in_ready), 64'h1);

    // T5: reset in CALC cycle 12, then 7*6.
    send(32'd9, 32'd9);
    repeat (11) @(posedge clk);
    #2 rst = 1'b1;
    #1 chk_reset_vals("t5");
    @(posedge clk);
    #1 rst = 1'b0;
    send(32'd7, 32'd6);
    wait_valid(n);
    chk("t5_hi", 64'(bus.out_hi), 64'h0);
    chk("t5_lo", 64'(bus.out_lo), 64'd42);
    @(posedge clk);
    #1;

    // T6: in_valid held with new operands during CALC/DONE.
    bus.in_a = 32'd11; bus.in_b = 32'd13; bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_a = 32'd99; bus.in_b = 32'd77;
    wait_valid(n);
    bus.in_valid = 1'b0;
    chk("t6_prod", {bus.out_hi, bus.out_lo}, 64'd143);
    @(posedge clk);
    #1;

    // Random sweep with edge operands mixed in.
    for (int i = 0; i < 200; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 10 == 0) rb = '0;
      if (i % 10 == 1) ra = 32'hFFFF_FFFF;
      if (i % 10 == 2) ra = 32'(
        $urandom_range(0, 255));
      send(ra, rb);
      wait_valid(n);
      @(posedge clk);
      #1;
    end

    repeat (3) @(negedge clk);
    chk("queue_empty", 64'(exp_q.size()), 64'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
